// File: rtl/ember_pkg.sv
// Shared definitions for the Ember writeback path: register-file geometry,
// the null register, and the request record carried through the FIFOs.
package ember_pkg;

  localparam int DATA_W = 64;
  localparam int NREGS  = 19;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_NULL = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // True when addr names an architectural register (R0 included).
  function automatic logic reg_in_range(logic [ADDR_W-1:0] addr, int nregs);
    return {{(32 - ADDR_W){1'b0}}, addr} < 32'(nregs);
  endfunction

endpackage

// File: rtl/ember_wb_arbiter_if.sv
// Bus bundle between the two result producers, the writeback arbiter and the
// register file write port.
//
// Handshake: a producer holds *_valid with stable addr/data until it sees
// *_ready high on a rising edge; the beat transfers on that edge. ready never
// depends on valid in the same cycle, and valid must not wait for ready.
interface ember_wb_arbiter_if #(
  parameter int DATA_W = ember_pkg::DATA_W,
  parameter int NREGS  = ember_pkg::NREGS
);
  import ember_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;

  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  logic              wr_en;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic [NREGS-1:0]  pend_mask;
  logic              addr_err;

  // Producer / register-file side.
  modport master (
    output alu_valid, alu_addr, alu_data,
    output ld_valid, ld_addr, ld_data,
    input  alu_ready, ld_ready,
    input  wr_en, wr1_addr, wr1_data, pend_mask, addr_err
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  ld_valid, ld_addr, ld_data,
    output alu_ready, ld_ready,
    output wr_en, wr1_addr, wr1_data, pend_mask, addr_err
  );

endinterface

// File: rtl/ember_wb_fifo.sv
// Small synchronous FIFO of writeback requests. Besides head/full/empty it
// exposes every slot's address and an occupancy vector so the parent can build
// the pending-write mask without knowing the pointer layout.
module ember_wb_fifo import ember_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  wb_req_t           din,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output wb_req_t           head,
  output logic [ADDR_W-1:0] entry_addr [DEPTH],
  output logic [DEPTH-1:0]  entry_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] off;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    entry_valid = '0;
    off         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_addr[i]  = mem[i].addr;
      off            = PTR_W'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, off} < count);
    end
  end

endmodule

// File: rtl/ember_wb_arbiter.sv
// Writeback arbiter: buffers ALU and load results, grants the single register
// file write port with load priority and a bounded ALU wait, and publishes the
// set of registers that still have a write in flight.
module ember_wb_arbiter #(
  parameter int DATA_W       = ember_pkg::DATA_W,
  parameter int NREGS        = ember_pkg::NREGS,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  ember_wb_arbiter_if.slave bus
);
  import ember_pkg::*;

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  wb_req_t           alu_in, ld_in, alu_head, ld_head;
  logic [ADDR_W-1:0] alu_ent [FIFO_DEPTH];
  logic [ADDR_W-1:0] ld_ent  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] alu_ev, ld_ev;
  logic              alu_full, alu_empty, ld_full, ld_empty;
  logic              alu_acc, ld_acc, alu_push, ld_push;
  logic              alu_win, ld_win;
  logic [SC_W-1:0]   starve_cnt;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr1_addr_q;
  logic [DATA_W-1:0] wr1_data_q;
  logic              addr_err_q;
  logic [NREGS-1:0]  pend;

  // Ready is purely "not full" so it never waits on this cycle's pop.
  assign bus.alu_ready = !alu_full;
  assign bus.ld_ready  = !ld_full;
  assign alu_acc = bus.alu_valid && !alu_full;
  assign ld_acc  = bus.ld_valid && !ld_full;

  // Null and out-of-range destinations are swallowed at the door.
  assign alu_push = alu_acc && (bus.alu_addr != REG_NULL) && reg_in_range(bus.alu_addr, NREGS);
  assign ld_push  = ld_acc && (bus.ld_addr != REG_NULL) && reg_in_range(bus.ld_addr, NREGS);
  assign alu_in   = '{addr: bus.alu_addr, data: bus.alu_data};
  assign ld_in    = '{addr: bus.ld_addr, data: bus.ld_data};

  ember_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk(clk), .rst(rst), .push(alu_push), .din(alu_in), .pop(alu_win),
    .full(alu_full), .empty(alu_empty), .head(alu_head),
    .entry_addr(alu_ent), .entry_valid(alu_ev)
  );

  ember_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_ld_fifo (
    .clk(clk), .rst(rst), .push(ld_push), .din(ld_in), .pop(ld_win),
    .full(ld_full), .empty(ld_empty), .head(ld_head),
    .entry_addr(ld_ent), .entry_valid(ld_ev)
  );

  // Load wins contention unless the ALU head has already lost STARVE_LIMIT times.
  always_comb begin
    alu_win = !alu_empty && (ld_empty || (starve_cnt == SC_W'(STARVE_LIMIT)));
    ld_win  = !ld_empty && !alu_win;
  end

  // Count consecutive losses of a waiting ALU head, saturating at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (alu_empty || alu_win) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SC_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

  // Register the winner onto the write port; address/data hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q    <= 1'b0;
      wr1_addr_q <= '0;
      wr1_data_q <= '0;
    end else if (alu_win) begin
      wr_en_q    <= 1'b1;
      wr1_addr_q <= alu_head.addr;
      wr1_data_q <= alu_head.data;
    end else if (ld_win) begin
      wr_en_q    <= 1'b1;
      wr1_addr_q <= ld_head.addr;
      wr1_data_q <= ld_head.data;
    end else begin
      wr_en_q    <= 1'b0;
    end
  end

  // Sticky flag for any accepted destination beyond the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_err_q <= 1'b0;
    end else if ((alu_acc && !reg_in_range(bus.alu_addr, NREGS)) ||
                 (ld_acc && !reg_in_range(bus.ld_addr, NREGS))) begin
      addr_err_q <= 1'b1;
    end
  end

  // Pending mask: every live FIFO slot plus the write currently on the port.
  always_comb begin
    pend = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (alu_ev[i]) pend[alu_ent[i]] = 1'b1;
      if (ld_ev[i])  pend[ld_ent[i]]  = 1'b1;
    end
    if (wr_en_q) pend[wr1_addr_q] = 1'b1;
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr1_addr  = wr1_addr_q;
  assign bus.wr1_data  = wr1_data_q;
  assign bus.pend_mask = pend;
  assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_ember_wb_arbiter.sv
// Self-checking bench for ember_wb_arbiter. A queue-based reference model
// tracks what each source has buffered, who should win each slot, and what the
// register file should finally hold.
module tb_ember_wb_arbiter;
  import ember_pkg::*;

  localparam int DW    = 64;
  localparam int NR    = 19;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  localparam int W     = ADDR_W + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ember_wb_arbiter_if #(.DATA_W(DW), .NREGS(NR)) bus ();

  ember_wb_arbiter #(
    .DATA_W(DW), .NREGS(NR), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- reference model state ----------------
  logic [W-1:0]  m_alu_q[$];
  logic [W-1:0]  m_ld_q[$];
  logic [W-1:0]  exp_q[$];
  int            m_starve;
  logic          m_wr_en;
  logic [4:0]    m_addr;
  logic [DW-1:0] m_data;
  logic          m_err;
  logic [DW-1:0] ref_rf [NR];
  logic [DW-1:0] dut_rf [NR];

  int checks = 0;
  int errors = 0;

  logic a_acc, l_acc;

  // Register file fed by the DUT's write port.
  always @(posedge clk) begin
    if (bus.wr_en) dut_rf[bus.wr1_addr] <= bus.wr1_data;
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_alu_q.delete();
    m_ld_q.delete();
    exp_q.delete();
    m_starve = 0;
    m_wr_en  = 1'b0;
    m_addr   = '0;
    m_data   = '0;
    m_err    = 1'b0;
  endtask

  // One rising edge of the specified behaviour, using the inputs the bench drove.
  task automatic model_step(output logic acc_a, output logic acc_l);
    logic [W-1:0] e;
    logic has_a, has_l, win_a, win_l;
    acc_a = bus.alu_valid && (m_alu_q.size() < DEPTH);
    acc_l = bus.ld_valid && (m_ld_q.size() < DEPTH);
    // The register file commits what was on the port before this edge.
    if (m_wr_en) ref_rf[m_addr] = m_data;
    has_a = m_alu_q.size() > 0;
    has_l = m_ld_q.size() > 0;
    win_a = has_a && (!has_l || m_starve == LIMIT);
    win_l = has_l && !win_a;
    e = '0;
    if (win_a) e = m_alu_q.pop_front();
    else if (win_l) e = m_ld_q.pop_front();
    if (win_a || win_l) begin
      m_wr_en = 1'b1;
      m_addr  = e[W-1:DW];
      m_data  = e[DW-1:0];
      exp_q.push_back(e);
    end else begin
      m_wr_en = 1'b0;
    end
    if (!has_a || win_a) m_starve = 0;
    else if (m_starve < LIMIT) m_starve = m_starve + 1;
    if (acc_a) begin
      if (int'(bus.alu_addr) >= NR) m_err = 1'b1;
      else if (bus.alu_addr != 0) m_alu_q.push_back({bus.alu_addr, bus.alu_data});
    end
    if (acc_l) begin
      if (int'(bus.ld_addr) >= NR) m_err = 1'b1;
      else if (bus.ld_addr != 0) m_ld_q.push_back({bus.ld_addr, bus.ld_data});
    end
  endtask

  function automatic logic [NR-1:0] model_mask();
    logic [NR-1:0] m;
    logic [W-1:0]  e;
    m = '0;
    foreach (m_alu_q[i]) begin e = m_alu_q[i]; m[e[W-1:DW]] = 1'b1; end
    foreach (m_ld_q[i])  begin e = m_ld_q[i];  m[e[W-1:DW]] = 1'b1; end
    if (m_wr_en) m[m_addr] = 1'b1;
    return m;
  endfunction

  task automatic check_outputs(input string ph);
    check({ph, ".wr_en"},     bus.wr_en,     m_wr_en);
    check({ph, ".wr1_addr"},  bus.wr1_addr,  m_addr);
    check({ph, ".wr1_data"},  bus.wr1_data,  m_data);
    check({ph, ".pend_mask"}, bus.pend_mask, model_mask());
    check({ph, ".alu_ready"}, bus.alu_ready, m_alu_q.size() < DEPTH);
    check({ph, ".ld_ready"},  bus.ld_ready,  m_ld_q.size() < DEPTH);
    check({ph, ".addr_err"},  bus.addr_err,  m_err);
    if (bus.wr_en) begin
      if (exp_q.size() > 0) check({ph, ".stream"}, {bus.wr1_addr, bus.wr1_data}, exp_q.pop_front());
      else                  check({ph, ".stream_extra"}, bus.wr_en, 1'b0);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic drive_cycle(input string ph,
                             input logic av, input logic [4:0] aa, input logic [DW-1:0] ad,
                             input logic lv, input logic [4:0] la, input logic [DW-1:0] ld,
                             output logic acc_a, output logic acc_l);
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.ld_valid  = lv; bus.ld_addr  = la; bus.ld_data  = ld;
    @(posedge clk);
    model_step(acc_a, acc_l);
    @(negedge clk);
    check_outputs(ph);
  endtask

  task automatic idle(input string ph, input int n);
    logic x, y;
    for (int i = 0; i < n; i++) drive_cycle(ph, 1'b0, '0, '0, 1'b0, '0, '0, x, y);
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int ai, li, guard;
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.ld_valid  = 1'b0; bus.ld_addr  = '0; bus.ld_data  = '0;
    for (int r = 0; r < NR; r++) begin ref_rf[r] = '0; dut_rf[r] = '0; end
    model_reset();

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst = 1'b1;

    // Single ALU write to R5.
    drive_cycle("single", 1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, '0, '0, a_acc, l_acc);
    idle("single", 3);

    // Contention: 8 ALU writes to R1..R8 against 8 loads to R9..R16.
    ai = 0; li = 0; guard = 0;
    while ((ai < 8 || li < 8) && guard < 100) begin
      drive_cycle("contend", ai < 8, 5'(ai + 1), rnd64(), li < 8, 5'(li + 9), rnd64(), a_acc, l_acc);
      if (a_acc) ai++;
      if (l_acc) li++;
      guard++;
    end
    if (guard >= 100) check("contend.timeout", ai + li, 16);
    idle("contend", 5);

    // Null register and out-of-range destination.
    drive_cycle("null", 1'b1, 5'd0, rnd64(), 1'b0, '0, '0, a_acc, l_acc);
    drive_cycle("inval", 1'b0, '0, '0, 1'b1, 5'd20, rnd64(), a_acc, l_acc);
    idle("inval", 3);

    // Back-pressure: both sources valid every cycle.
    for (int i = 0; i < 10; i++)
      drive_cycle("bp", 1'b1, 5'($urandom_range(1, 18)), rnd64(),
                  1'b1, 5'($urandom_range(1, 18)), rnd64(), a_acc, l_acc);
    idle("bp", 5);

    // Random traffic including null and invalid addresses.
    for (int i = 0; i < 300; i++)
      drive_cycle("rand", $urandom_range(0, 3) != 0, 5'($urandom_range(0, 22)), rnd64(),
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 22)), rnd64(), a_acc, l_acc);
    idle("rand", 6);

    // Reset mid-flight with three entries buffered and one on the port.
    drive_cycle("mid", 1'b1, 5'd3, rnd64(), 1'b1, 5'd4, rnd64(), a_acc, l_acc);
    drive_cycle("mid", 1'b1, 5'd6, rnd64(), 1'b1, 5'd7, rnd64(), a_acc, l_acc);
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outputs("midreset");
    @(negedge clk);
    rst = 1'b1;
    idle("postreset", 6);

    // Final register file contents.
    for (int r = 1; r < NR; r++) check($sformatf("rf.r%0d", r), dut_rf[r], ref_rf[r]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ember_wb_arbiter.md
# ember_wb_arbiter

Writeback arbiter for the Ember core. It merges results from two producers, the ALU and the load unit, onto the register file's single write port (wr_en / wr1_addr / wr1_data). It buffers each producer in a small FIFO and arbitrates with load priority plus an ALU anti-starvation limit. It also exports a pending-write mask for the issue stage's hazard checks.

## Interface
Parameters:
- DATA_W, 64, result width; equals register width.
- NREGS, 19, architectural registers R0..R18; R0 is the null register.
- FIFO_DEPTH, 2, entries per source FIFO; power of two, at least 2.
- STARVE_LIMIT, 4, consecutive cycles a waiting ALU head may lose before it is forced to win.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- alu_valid / alu_ready  in / out  1 / 1  ALU result handshake.
- alu_addr / alu_data  in  5 / DATA_W  ALU destination register and value.
- ld_valid / ld_ready  in / out  1 / 1  load result handshake.
- ld_addr / ld_data  in  5 / DATA_W  load destination register and value.
- wr_en  out  1  register file write enable; registered.
- wr1_addr  out  5  register file write address; registered.
- wr1_data  out  DATA_W  register file write data; registered.
- pend_mask  out  NREGS  bit r is set while any buffered or issuing write targets Rr.
- addr_err  out  1  sticky flag: an address ≥ NREGS was accepted.

## Operation
- Transfer occurs on a rising edge with valid && ready. Each ready signal equals "own FIFO not full" and does not depend on the same cycle's pop.
- Accepted entries with addr == 0 or addr ≥ NREGS are consumed and never enqueued. An address ≥ NREGS also sets addr_err, which only rst clears.
- Arbitration runs each cycle over the two FIFO heads:
  - If only one head is present, that head wins.
  - If both are present, load wins, unless starve_cnt == STARVE_LIMIT; then ALU wins.
- starve_cnt increments when the ALU head is present and loses. It clears when the ALU wins or its FIFO is empty, and saturates at STARVE_LIMIT.
- The winner is popped, and its addr/data are registered onto wr1_addr/wr1_data with wr_en = 1. With no winner, wr_en = 0 and wr1_addr/wr1_data hold their previous values.
- Ordering:
  - Entries from the same source issue in acceptance order.
  - Across sources there is no ordering guarantee. Upstream must not have two in-flight writes to one register from different sources.
- pend_mask is combinational: the OR of one-hot decodes of every valid FIFO entry plus the output register when wr_en = 1.

## Timing
- Reset (rst low, async):
  - wr_en = 0, wr1_addr = 0, wr1_data = 0.
  - Both FIFOs are empty, so alu_ready = ld_ready = 1 after release.
  - pend_mask = 0, addr_err = 0, starve_cnt = 0.
- Latency: an entry accepted at edge E can drive wr_en high from edge E+1. The register file commits it at edge E+2.
- Throughput: one write per cycle sustained. Each source can be accepted every cycle while its FIFO is not full.
- Full FIFO: ready is low for that source. A pop in the same cycle frees a slot visible from the next cycle.
- Simultaneous push and pop on a non-full FIFO: both occur, and the occupancy is unchanged.
- Pointers wrap modulo FIFO_DEPTH. The count width is clog2(FIFO_DEPTH)+1.
- Reset mid-operation: all buffered writes are discarded and wr_en drops immediately. No partial write is presented.

## Structure
- The shared package ember_pkg holds:
  - the constants DATA_W, NREGS and REG_NULL = 0;
  - the typedef wb_req_t {addr[4:0], data[DATA_W-1:0]}.
- Sub-module ember_wb_fifo: a parameterised synchronous FIFO with push/pop/full/empty/head, plus an entry-valid vector for the mask. It is instantiated twice.
- The top level contains the arbiter, the starvation counter, the output register and the mask OR tree.

## Test plan
- Reset: hold rst low for 2 cycles → wr_en = 0, pend_mask = 0, both readies = 1, addr_err = 0.
- Single ALU write: R5 = 64'hDEAD_BEEF accepted at edge E → wr_en = 1 with wr1_addr = 5 after E+1. pend_mask[5] stays set until the cycle after that issue.
- Contention: both sources hold 8 writes each (ALU to R1..R8, load to R9..R16) → issue order is load, load, load, load, ALU, load, ... with the ALU winning every 5th slot. All 16 writes appear and ld_ready/alu_ready toggle on full.
- Null/invalid: ALU write to R0, then load write to R20 → neither issues (wr_en stays 0) and addr_err = 1 and stays set.
- Back-pressure: both valids held high for 10 cycles, none dropped → exactly 1 write per cycle. The regfile read of each target after completion matches the data sent.
- Reset mid-flight: pull rst low while 3 entries are queued → wr_en = 0 immediately, and none of those 3 writes appear after release.
